// File: rtl/dram_wb_bridge_pkg.sv
// Shared definitions for the data-RAM front end: macro geometry and the
// encoding of which requester owns the read data returning from the macro.
package dram_wb_bridge_pkg;

    localparam int DRAM_ADDR_W = 8;
    localparam int DRAM_DATA_W = 32;
    localparam int DRAM_BE_W   = DRAM_DATA_W / 8;

    // Owner of the macro read issued in the previous cycle
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CORE = 2'd1,
        RD_WB   = 2'd2
    } rd_src_e;

endpackage

// File: rtl/dram_wb_bridge.sv
// Single-port front end for the OpenRAM 1rw data macro. The core data port
// and the Caravel Wishbone slave share one macro access per cycle. The core
// wins by default; a starvation counter forces a waiting Wishbone request
// through after STARVE_LIMIT lost cycles so firmware can always reach DRAM.
module dram_wb_bridge
    import dram_wb_bridge_pkg::*;
#(
    parameter int ADDR_W       = DRAM_ADDR_W,
    parameter int DATA_W       = DRAM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    // core data port
    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [DATA_W/8-1:0] core_be_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_wdata_i,
    output logic                core_gnt_o,
    output logic                core_rvalid_o,
    output logic [DATA_W-1:0]   core_rdata_o,
    // Wishbone classic slave
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [DATA_W/8-1:0] wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [DATA_W-1:0]   wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [DATA_W-1:0]   wbs_dat_o,
    // RAM macro port
    output logic                csb0_o,
    output logic                web0_o,
    output logic [DATA_W/8-1:0] wmask0_o,
    output logic [ADDR_W-1:0]   addr0_o,
    output logic [DATA_W-1:0]   din0_o,
    input  logic [DATA_W-1:0]   dout0_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic             wb_busy_q, wb_busy_d;
    rd_src_e          rd_src_q, rd_src_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [BE_W-1:0]   wmask_q;

    logic wb_pend, wb_force, issue_core, issue_wb;
    logic [ADDR_W-1:0] wb_word;
    logic unused_adr;

    // Byte address to word address; upper bits alias because decode is upstream
    assign wb_word    = wbs_adr_i[ADDR_W+1:2];
    assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

    // Responses: ack is dropped if the master abandons the cycle or reset hits
    assign wbs_ack_o     = wb_busy_q & wbs_cyc_i & rstn_i;
    assign wbs_dat_o     = (rd_src_q == RD_WB) ? dout0_i : '0;
    assign core_rvalid_o = (rd_src_q == RD_CORE) & rstn_i;
    assign core_rdata_o  = dout0_i;

    // Arbitration: the ack cycle blocks a back-to-back Wishbone reissue
    assign wb_pend    = wbs_cyc_i & wbs_stb_i & ~wb_busy_q & ~wbs_ack_o;
    assign wb_force   = wb_pend & (starve_q == CNT_W'(STARVE_LIMIT));
    assign issue_core = rstn_i & core_req_i & ~wb_force;
    assign issue_wb   = rstn_i & ~issue_core & wb_pend;
    assign core_gnt_o = issue_core;

    // Macro drive for the winning requester; idle keeps the last address/data
    always_comb begin
        csb0_o   = 1'b1;
        web0_o   = 1'b1;
        wmask0_o = wmask_q;
        addr0_o  = addr_q;
        din0_o   = din_q;
        if (issue_core) begin
            csb0_o   = 1'b0;
            web0_o   = ~core_we_i;
            wmask0_o = core_be_i;
            addr0_o  = core_addr_i;
            din0_o   = core_wdata_i;
        end else if (issue_wb) begin
            csb0_o   = 1'b0;
            web0_o   = ~wbs_we_i;
            wmask0_o = wbs_sel_i;
            addr0_o  = wb_word;
            din0_o   = wbs_dat_i;
        end
    end

    // Next-state for busy flag, read-data owner and starvation counter
    always_comb begin
        wb_busy_d = issue_wb;
        rd_src_d  = RD_NONE;
        if (issue_core && !core_we_i) begin
            rd_src_d = RD_CORE;
        end else if (issue_wb && !wbs_we_i) begin
            rd_src_d = RD_WB;
        end
        starve_d = starve_q;
        if (!wb_pend || issue_wb) begin
            starve_d = '0;
        end else if (issue_core && (starve_q != CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Control state; a reset mid-access simply forgets the pending response
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wb_busy_q <= 1'b0;
            rd_src_q  <= RD_NONE;
            starve_q  <= '0;
        end else begin
            wb_busy_q <= wb_busy_d;
            rd_src_q  <= rd_src_d;
            starve_q  <= starve_d;
        end
    end

    // Hold registers so idle cycles keep the macro address/data lines stable
    always_ff @(posedge clk_i) begin
        if (issue_core || issue_wb) begin
            addr_q  <= addr0_o;
            din_q   <= din0_o;
            wmask_q <= wmask0_o;
        end
    end

endmodule

// File: tb/tb_dram_wb_bridge.sv
// Directed bench for dram_wb_bridge with a 1-cycle-read behavioural RAM model
// and a scoreboard that checks every Wishbone ack and core rvalid.
module tb_dram_wb_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        core_req, core_we;
    logic [3:0]  core_be;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat_w;
    logic        wbs_ack;
    logic [31:0] wbs_dat_r;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0 = 32'h0;

    dram_wb_bridge #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we), .wbs_sel_i(wbs_sel),
        .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat_w), .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat_r),
        .csb0_o(csb0), .web0_o(web0), .wmask0_o(wmask0), .addr0_o(addr0),
        .din0_o(din0), .dout0_i(dout0)
    );

    always #5 clk = ~clk;

    // Behavioural 1rw macro: synchronous write with byte mask, 1-cycle read
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t wb_q[$];
    exp_t core_q[$];
    exp_t e_wb, e_core;
    int n_vec = 0;
    int n_bad = 0;

    function automatic exp_t mk(int unsigned c, logic [31:0] d, bit k);
        exp_t r;
        r.cyc  = c;
        r.data = d;
        r.chk  = k;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // Monitor: every response the DUT presents must match the head of its queue
    always @(negedge clk) begin
        if (wbs_ack) begin
            if (wb_q.size() == 0) begin
                check("wb_ack_unexpected", 32'd1, 32'd0);
            end else begin
                e_wb = wb_q.pop_front();
                check("wb_ack_cycle", cyc_n, e_wb.cyc);
                if (e_wb.chk) check("wb_rdata", wbs_dat_r, e_wb.data);
            end
        end
        if (core_rvalid) begin
            if (core_q.size() == 0) begin
                check("core_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e_core = core_q.pop_front();
                check("core_rvalid_cycle", cyc_n, e_core.cyc);
                if (e_core.chk) check("core_rdata", core_rdata, e_core.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wishbone transfer with the core idle; lat is the hand-computed issue-to-ack distance
    task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int lat, input logic [31:0] exp_rd,
                          input bit chk_issue, input logic [7:0] exp_word);
        bit got;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
        wbs_adr = adr; wbs_dat_w = dat; wbs_sel = sel;
        wb_q.push_back(mk(cyc_n + lat, exp_rd, !we));
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (i == 0 && chk_issue) begin
                check("wb_issue_csb0", {31'd0, csb0}, 32'd0);
                check("wb_issue_web0", {31'd0, web0}, {31'd0, ~we});
                check("wb_issue_addr0", {24'd0, addr0}, {24'd0, exp_word});
                check("wb_issue_wmask0", {28'd0, wmask0}, {28'd0, sel});
                if (we) check("wb_issue_din0", din0, dat);
            end
            if (wbs_ack) got = 1'b1;
        end
        check("wb_ack_seen", {31'd0, got}, 32'd1);
        tick();
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    // Core access with Wishbone idle: grant is expected in the request cycle
    task automatic core_acc(input logic we, input logic [3:0] be, input logic [7:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rd);
        bit got;
        core_req = 1'b1; core_we = we; core_be = be; core_addr = addr; core_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (core_gnt) begin
                got = 1'b1;
                check("core_gnt_latency", i, 0);
                check("core_csb0", {31'd0, csb0}, 32'd0);
                if (we) check("core_wmask0", {28'd0, wmask0}, {28'd0, be});
                else core_q.push_back(mk(cyc_n + 1, exp_rd, 1'b1));
            end
        end
        check("core_gnt_seen", {31'd0, got}, 32'd1);
        tick();
        core_req = 1'b0; core_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int unsigned s;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rstn = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_be = 4'hF; core_addr = 8'd3; core_wdata = 32'h0;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_sel = 4'h0;
        wbs_adr = 32'h0; wbs_dat_w = 32'h0;

        // reset held with the core requesting: no access, no grant, no responses
        repeat (3) tick();
        @(negedge clk);
        check("rst_csb0", {31'd0, csb0}, 32'd1);
        check("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
        check("rst_wbs_ack", {31'd0, wbs_ack}, 32'd0);
        check("rst_core_rvalid", {31'd0, core_rvalid}, 32'd0);
        tick();
        core_req = 1'b0;
        rstn = 1'b1;

        // WB write then read back, core idle
        wb_req(1'b1, 32'h3000_0004, 32'hAB61_0000, 4'hF, 1, 32'h0, 1'b1, 8'd1);
        wb_req(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 32'hAB61_0000, 1'b1, 8'd1);

        // core byte write into lane 1, then read the merged word
        core_acc(1'b1, 4'b0010, 8'd1, 32'h0000_CD00, 32'h0);
        core_acc(1'b0, 4'hF, 8'd1, 32'h0, 32'hAB61_CD00);

        // contention: core reads continuously, WB read forced through on the 5th cycle
        tick();
        s = cyc_n;
        core_req = 1'b1; core_we = 1'b0; core_be = 4'hF; core_addr = 8'd1;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_sel = 4'hF; wbs_adr = 32'h3000_0004;
        wb_q.push_back(mk(s + 5, 32'hAB61_CD00, 1'b1));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("contention_gnt", {31'd0, core_gnt}, (k == 4) ? 32'd0 : 32'd1);
            if (k != 4) core_q.push_back(mk(s + k + 1, 32'hAB61_CD00, 1'b1));
        end
        tick();
        core_req = 1'b0;
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        tick();

        // WB write abandoned in its ack cycle: no ack, but memory updated
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_sel = 4'hF;
        wbs_adr = 32'h3000_0008; wbs_dat_w = 32'h1234_5678;
        @(negedge clk);
        check("drop_issue_csb0", {31'd0, csb0}, 32'd0);
        tick();
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        @(negedge clk);
        check("drop_wbs_ack", {31'd0, wbs_ack}, 32'd0);
        tick();
        core_acc(1'b0, 4'hF, 8'd2, 32'h0, 32'h1234_5678);
        // next WB request serviced normally; upper address bits alias to word 2
        wb_req(1'b0, 32'h3000_0408, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b1, 8'd2);

        // reset pulsed the cycle after a WB read issue: that ack never appears
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_sel = 4'hF; wbs_adr = 32'h3000_0004;
        @(negedge clk);
        check("rstpulse_issue_csb0", {31'd0, csb0}, 32'd0);
        tick();
        rstn = 1'b0;
        @(negedge clk);
        check("rstpulse_wbs_ack", {31'd0, wbs_ack}, 32'd0);
        tick();
        rstn = 1'b1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        tick();
        wb_req(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 32'hAB61_CD00, 1'b0, 8'd1);

        repeat (3) tick();
        check("wb_queue_drained", wb_q.size(), 32'd0);
        check("core_queue_drained", core_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
